fp_mult_pipe: RTL

//  Parametrised, 3-stage pipelined IEEE-754 multiplier with valid/ready flow control on input and output.

---
 rtl/fp_mult_pkg.sv | 52 +++++
 rtl/fp_round_unit.sv | 53 +++++
 rtl/fp_mult_pipe.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mult_pkg.sv
// -----------------------------------------------------------------------------
// fp_mult_pkg
// Shared types and helpers for the pipelined floating-point multiplier.
//   round_mode_t  : rounding mode encoding carried down the pipe
//   ST_*          : bit positions inside the 8-bit status word
//   op_class_t    : operand/result class decided in stage 1
//   bias()        : exponent bias for a given exponent width
//   to_round_mode : maps the raw 3-bit mode input, folding 6/7 onto ties-to-even
// -----------------------------------------------------------------------------
package fp_mult_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,  // ties to even
      RM_RTZ = 3'd1,  // toward zero
      RM_RUP = 3'd2,  // toward +inf
      RM_RDN = 3'd3,  // toward -inf
      RM_RNA = 3'd4,  // ties away from zero
      RM_RAZ = 3'd5   // away from zero
   } round_mode_t;

   localparam int ST_ZERO    = 0;
   localparam int ST_INF     = 1;
   localparam int ST_NAN     = 2;
   localparam int ST_TINY    = 3;
   localparam int ST_HUGE    = 4;
   localparam int ST_INEXACT = 5;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      ZERO   = 2'd1,
      INF    = 2'd2,
      NAN    = 2'd3
   } op_class_t;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic round_mode_t to_round_mode(input logic [2:0] rnd);
      round_mode_t m;
      case (rnd)
         3'd1:    m = RM_RTZ;
         3'd2:    m = RM_RUP;
         3'd3:    m = RM_RDN;
         3'd4:    m = RM_RNA;
         3'd5:    m = RM_RAZ;
         default: m = RM_RNE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fp_round_unit.sv
// -----------------------------------------------------------------------------
// fp_round_unit
// Combinational rounding of a normalised significand (used in stage 3).
//   i_mant     : significand including hidden bit (MAN_W+1 bits)
//   i_guard    : first bit below the LSB
//   i_sticky   : OR of all bits below the guard bit
//   i_sign     : result sign (for directed modes)
//   i_mode     : rounding mode
//   o_frac     : rounded stored fraction (hidden bit dropped)
//   o_exp_inc  : rounding carried out of the significand; exponent must be +1
//   o_inexact  : discarded bits were non-zero
// -----------------------------------------------------------------------------
module fp_round_unit
   import fp_mult_pkg::*;
#(
   parameter int MAN_W = 23
) (
   input  logic [MAN_W:0]   i_mant,
   input  logic             i_guard,
   input  logic             i_sticky,
   input  logic             i_sign,
   input  round_mode_t      i_mode,
   output logic [MAN_W-1:0] o_frac,
   output logic             o_exp_inc,
   output logic             o_inexact
);

   logic             w_up;
   logic             w_lost;
   logic [MAN_W+1:0] w_sum;

   assign w_lost = i_guard | i_sticky;

   always_comb begin
      w_up = 1'b0;
      case (i_mode)
         RM_RTZ:  w_up = 1'b0;
         RM_RUP:  w_up = w_lost & ~i_sign;
         RM_RDN:  w_up = w_lost & i_sign;
         RM_RNA:  w_up = i_guard;
         RM_RAZ:  w_up = w_lost;
         default: w_up = i_guard & (i_sticky | i_mant[0]);
      endcase
   end

   assign w_sum = {1'b0, i_mant} + {{(MAN_W + 1){1'b0}}, w_up};

   // On carry-out the sum is 10..0, so its upper fraction slice is already zero.
   assign o_frac    = w_sum[MAN_W+1] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
   assign o_exp_inc = w_sum[MAN_W+1];
   assign o_inexact = w_lost;

endmodule

// File: rtl/fp_mult_pipe.sv
// -----------------------------------------------------------------------------
// fp_mult_pipe
// Three-stage pipelined IEEE-754 multiplier with valid/ready on both sides and
// a user tag travelling with every operation. EXP_W/MAN_W = 8/23 is binary32.
// Optional feature macro: FP_MULT_STICKY_FLAGS_EN (adds i_flags_clr/o_flags).
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operands/mode/tag valid
//   o_in_ready   stage 1 can accept this cycle
//   i_a, i_b     operands (W bits)
//   i_rnd        rounding mode (round_mode_t; 6/7 act as ties-to-even)
//   i_in_tag     user tag
//   o_out_valid  result valid
//   i_out_ready  consumer accepts this cycle
//   o_z          product
//   o_status     [0]zero [1]inf [2]nan [3]tiny [4]huge [5]inexact [7:6]=0
//   o_out_tag    tag of the result
//   i_flags_clr  (macro) clear accumulated flags
//   o_flags      (macro) OR of status[5:0] of every delivered result
//
// Stages: S1 unpack/classify/exponent sum/significand product,
//         S2 normalise and guard/sticky extraction,
//         S3 round, renormalise, exceptions; S3 registers are the outputs.
// -----------------------------------------------------------------------------
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   parameter  int TAG_W = 4,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [W-1:0]     i_a,
   input  logic [W-1:0]     i_b,
   input  logic [2:0]       i_rnd,
   input  logic [TAG_W-1:0] i_in_tag,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [W-1:0]     o_z,
   output logic [7:0]       o_status,
   output logic [TAG_W-1:0] o_out_tag
`ifdef FP_MULT_STICKY_FLAGS_EN
   ,
   input  logic             i_flags_clr,
   output logic [5:0]       o_flags
`endif
);

   localparam int EW2 = EXP_W + 2;
   localparam int MW1 = MAN_W + 1;
   localparam int PW  = 2 * MW1;

   localparam logic signed [EW2-1:0] BIAS_S    = EW2'(bias(EXP_W));
   localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'((1 << EXP_W) - 1);

   function automatic op_class_t classify(input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] f);
      op_class_t c;
      if (e == '1)      c = (f != '0) ? NAN : INF;
      else if (e == '0) c = ZERO;  // subnormals flush to zero
      else              c = NORMAL;
      return c;
   endfunction

   // ---------------------------------------------------------------- flow
   logic r_s1_v, r_s2_v, r_s3_v;
   logic w_s1_free, w_s2_free, w_s3_free;

   // A stage may load when it is empty or its content moves on this cycle.
   assign w_s3_free  = ~r_s3_v | i_out_ready;
   assign w_s2_free  = ~r_s2_v | w_s3_free;
   assign w_s1_free  = ~r_s1_v | w_s2_free;
   assign o_in_ready = w_s1_free;

   // ---------------------------------------------------------------- S1
   logic [EXP_W-1:0]     w_a_exp, w_b_exp;
   logic [MAN_W-1:0]     w_a_frac, w_b_frac;
   op_class_t            w_a_cls, w_b_cls, w_s1_cls;
   logic signed [EW2-1:0] w_exp_sum;
   logic [MW1-1:0]       w_a_mant, w_b_mant;
   logic [PW-1:0]        w_prod;

   assign w_a_exp  = i_a[W-2:MAN_W];
   assign w_b_exp  = i_b[W-2:MAN_W];
   assign w_a_frac = i_a[MAN_W-1:0];
   assign w_b_frac = i_b[MAN_W-1:0];
   assign w_a_cls  = classify(w_a_exp, w_a_frac);
   assign w_b_cls  = classify(w_b_exp, w_b_frac);
   assign w_a_mant = {1'b1, w_a_frac};
   assign w_b_mant = {1'b1, w_b_frac};
   assign w_prod   = w_a_mant * w_b_mant;
   assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS_S;

   always_comb begin
      w_s1_cls = NORMAL;
      if (w_a_cls == NAN || w_b_cls == NAN ||
          (w_a_cls == INF && w_b_cls == ZERO) || (w_a_cls == ZERO && w_b_cls == INF)) begin
         w_s1_cls = NAN;
      end else if (w_a_cls == INF || w_b_cls == INF) begin
         w_s1_cls = INF;
      end else if (w_a_cls == ZERO || w_b_cls == ZERO) begin
         w_s1_cls = ZERO;
      end
   end

   logic                  r_s1_sign;
   op_class_t             r_s1_cls;
   logic signed [EW2-1:0] r_s1_exp;
   logic [PW-1:0]         r_s1_prod;
   round_mode_t           r_s1_mode;
   logic [TAG_W-1:0]      r_s1_tag;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_sign <= 1'b0;
         r_s1_cls  <= NORMAL;
         r_s1_exp  <= '0;
         r_s1_prod <= '0;
         r_s1_mode <= RM_RNE;
         r_s1_tag  <= '0;
      end else if (w_s1_free) begin
         r_s1_v <= i_in_valid;
         if (i_in_valid) begin
            r_s1_sign <= i_a[W-1] ^ i_b[W-1];
            r_s1_cls  <= w_s1_cls;
            r_s1_exp  <= w_exp_sum;
            r_s1_prod <= w_prod;
            r_s1_mode <= to_round_mode(i_rnd);
            r_s1_tag  <= i_in_tag;
         end
      end
   end

   // ---------------------------------------------------------------- S2
   logic                  w_norm_hi;
   logic [MW1-1:0]        w_s2_mant;
   logic                  w_s2_guard, w_s2_sticky;
   logic signed [EW2-1:0] w_s2_exp;

   // Product of two [1,2) significands lies in [1,4); a set MSB means >= 2.
   assign w_norm_hi = r_s1_prod[PW-1];
   assign w_s2_exp  = r_s1_exp + $signed({{(EW2 - 1){1'b0}}, w_norm_hi});

   always_comb begin
      w_s2_mant   = r_s1_prod[PW-2 -: MW1];
      w_s2_guard  = r_s1_prod[MAN_W-1];
      w_s2_sticky = |r_s1_prod[MAN_W-2:0];
      if (w_norm_hi) begin
         w_s2_mant   = r_s1_prod[PW-1 -: MW1];
         w_s2_guard  = r_s1_prod[MAN_W];
         w_s2_sticky = |r_s1_prod[MAN_W-1:0];
      end
   end

   logic                  r_s2_sign;
   op_class_t             r_s2_cls;
   logic signed [EW2-1:0] r_s2_exp;
   logic [MW1-1:0]        r_s2_mant;
   logic                  r_s2_guard, r_s2_sticky;
   round_mode_t           r_s2_mode;
   logic [TAG_W-1:0]      r_s2_tag;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_v      <= 1'b0;
         r_s2_sign   <= 1'b0;
         r_s2_cls    <= NORMAL;
         r_s2_exp    <= '0;
         r_s2_mant   <= '0;
         r_s2_guard  <= 1'b0;
         r_s2_sticky <= 1'b0;
         r_s2_mode   <= RM_RNE;
         r_s2_tag    <= '0;
      end else if (w_s2_free) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_sign   <= r_s1_sign;
            r_s2_cls    <= r_s1_cls;
            r_s2_exp    <= w_s2_exp;
            r_s2_mant   <= w_s2_mant;
            r_s2_guard  <= w_s2_guard;
            r_s2_sticky <= w_s2_sticky;
            r_s2_mode   <= r_s1_mode;
            r_s2_tag    <= r_s1_tag;
         end
      end
   end

   // ---------------------------------------------------------------- S3
   logic [MAN_W-1:0]      w_frac;
   logic                  w_exp_inc, w_inexact;
   logic signed [EW2-1:0] w_exp_post;
   logic                  w_ovf, w_unf, w_away, w_to_inf;
   logic [W-1:0]          w_z;
   logic [7:0]            w_status;

   fp_round_unit #(
      .MAN_W (MAN_W)
   ) u_round (
      .i_mant    (r_s2_mant),
      .i_guard   (r_s2_guard),
      .i_sticky  (r_s2_sticky),
      .i_sign    (r_s2_sign),
      .i_mode    (r_s2_mode),
      .o_frac    (w_frac),
      .o_exp_inc (w_exp_inc),
      .o_inexact (w_inexact)
   );

   assign w_exp_post = r_s2_exp + $signed({{(EW2 - 1){1'b0}}, w_exp_inc});
   assign w_ovf      = (w_exp_post >= EXP_MAX_S);
   assign w_unf      = w_exp_post[EW2-1] | (w_exp_post == '0);

   // Directed modes that push the magnitude away from zero for this sign.
   assign w_away   = (r_s2_mode == RM_RAZ) ||
                     (r_s2_mode == RM_RUP && !r_s2_sign) ||
                     (r_s2_mode == RM_RDN && r_s2_sign);
   assign w_to_inf = w_away || (r_s2_mode == RM_RNE) || (r_s2_mode == RM_RNA);

   always_comb begin
      w_z      = '0;
      w_status = '0;
      case (r_s2_cls)
         NAN: begin
            w_z                = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
            w_status[ST_NAN]   = 1'b1;
         end
         INF: begin
            w_z                = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_status[ST_INF]   = 1'b1;
         end
         ZERO: begin
            w_z                = {r_s2_sign, {(W - 1){1'b0}}};
            w_status[ST_ZERO]  = 1'b1;
         end
         default: begin
            if (w_ovf) begin
               w_status[ST_HUGE]    = 1'b1;
               w_status[ST_INEXACT] = 1'b1;
               if (w_to_inf) begin
                  w_z              = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  w_status[ST_INF] = 1'b1;
               end else begin
                  w_z = {r_s2_sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
               end
            end else if (w_unf) begin
               w_status[ST_TINY]    = 1'b1;
               w_status[ST_INEXACT] = 1'b1;
               if (w_away) begin
                  w_z = {r_s2_sign, {(EXP_W - 1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
               end else begin
                  w_z               = {r_s2_sign, {(W - 1){1'b0}}};
                  w_status[ST_ZERO] = 1'b1;
               end
            end else begin
               w_z                  = {r_s2_sign, w_exp_post[EXP_W-1:0], w_frac};
               w_status[ST_INEXACT] = w_inexact;
            end
         end
      endcase
   end

   logic [W-1:0]     r_z;
   logic [7:0]       r_status;
   logic [TAG_W-1:0] r_tag;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s3_v   <= 1'b0;
         r_z      <= '0;
         r_status <= '0;
         r_tag    <= '0;
      end else if (w_s3_free) begin
         r_s3_v <= r_s2_v;
         if (r_s2_v) begin
            r_z      <= w_z;
            r_status <= w_status;
            r_tag    <= r_s2_tag;
         end
      end
   end

   assign o_out_valid = r_s3_v;
   assign o_z         = r_z;
   assign o_status    = r_status;
   assign o_out_tag   = r_tag;

`ifdef FP_MULT_STICKY_FLAGS_EN
   logic [5:0] r_flags;

   // Clear takes effect first, so a same-cycle delivery still lands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flags <= '0;
      end else begin
         r_flags <= (i_flags_clr ? 6'd0 : r_flags) |
                    ((r_s3_v & i_out_ready) ? r_status[5:0] : 6'd0);
      end
   end

   assign o_flags = r_flags;
`endif

endmodule
